seg_scan_multi: RTL



---
 rtl/seg_pkg.sv | 37 +++
 rtl/seg_decode.sv | 35 +++
 rtl/seg_scan_multi.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment patterns, scan state encoding and sizing helper
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  // floor(log2(x)); returns 0 for x <= 1
  function automatic int logb2(input int x);
    int r;
    r = 0;
    for (int v = x; v > 1; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// rtl/seg_decode.sv - nibble to abcdefg decoder
// SEG_HEX_EN defined: 10-15 show A,b,C,d,E,F; otherwise they are blank.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nib_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
`ifdef SEG_HEX_EN
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
`endif
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_multi.sv
// rtl/seg_scan_multi.sv - multi-digit seven-segment scanner with double-buffered values
// Hex glyphs for nibbles 10-15 are enabled by SEG_HEX_EN (see seg_decode).
module seg_scan_multi #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lz_blank,
  output logic [DIGITS-1:0]     csn,
  output logic [6:0]            abcdefg,
  output logic                  dp,
  output logic                  frame_done
);
  import seg_pkg::*;

  localparam int DIV_W = logb2(SCAN_DIV - 1) + 1;
  localparam int IDX_W = logb2(DIGITS - 1) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [4*DIGITS-1:0]   pend_q, pend_d, act_q, act_d;
  logic [DIGITS-1:0]     pdp_q, pdp_d, adp_q, adp_d;
  logic [DIGITS-1:0]     csn_q, csn_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic [3:0]            nib_sel;
  logic [6:0]            dec_seg;
  logic [DIGITS-1:0]     blank;
  logic                  zero_run;

  // A load on the copy cycle is forwarded through pend_d, so din lands in active directly
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    div_d   = div_q;
    fd_d    = 1'b0;
    pend_d  = load ? din   : pend_q;
    pdp_d   = load ? dp_in : pdp_q;
    act_d   = act_q;
    adp_d   = adp_q;
    case (state_q)
      ST_IDLE: begin
        act_d = pend_d;
        adp_d = pdp_d;
        if (en) begin
          state_d = ST_SCAN;
          idx_d   = '0;
          div_d   = '0;
        end
      end
      ST_SCAN: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            fd_d  = 1'b1;
            act_d = pend_d;
            adp_d = pdp_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit i>0 blanks when it and every more-significant nibble are zero
  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (act_d[4*i +: 4] == 4'd0);
      blank[i] = lz_blank & zero_run & (i > 0);
    end
  end

  assign nib_sel = act_d[{idx_d, 2'b00} +: 4];

  seg_decode u_dec (
    .nib_i (nib_sel),
    .seg_o (dec_seg)
  );

  // Outputs are computed from next-state so they track idx one cycle after the decision
  always_comb begin
    csn_d = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b0;
    if (state_d == ST_SCAN) begin
      csn_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_d);
      seg_d = blank[idx_d] ? SEG_BLANK : dec_seg;
      dp_d  = adp_d[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      div_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      act_q   <= '0;
      adp_q   <= '0;
      csn_q   <= '1;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      div_q   <= div_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      act_q   <= act_d;
      adp_q   <= adp_d;
      csn_q   <= csn_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fd_q    <= fd_d;
    end
  end

  assign csn        = csn_q;
  assign abcdefg    = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule
